// File: rtl/cnn_acc_requant_22s_14s.sv
// rtl/cnn_acc_requant_22s_14s.sv - accumulates NUM_TERMS signed products plus a scaled bias and requantizes to 14s
// Optional build macro CNN_ACC_REQUANT_RELU_EN clamps negative results to zero.
module cnn_acc_requant_22s_14s #(
  parameter int NUM_TERMS = 25,
  parameter int SHIFT     = 8,
  parameter int ACC_WIDTH = 32
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               prod_vld,
  output logic               prod_rdy,
  input  logic signed [21:0] prod_din,
  input  logic signed [13:0] bias_din,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic signed [13:0] out_dout,
  output logic               busy
);

  localparam int CW = $clog2(NUM_TERMS + 1);
  localparam logic signed [ACC_WIDTH-1:0] ROUND_C = ACC_WIDTH'(1) << (SHIFT - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'(8191);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = -ACC_WIDTH'(8192);

  typedef enum logic [1:0] {IDLE, ACC, ROUND, HOLD} state_t;

  state_t                       state;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic        [CW-1:0]         count;
  logic                         accept;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  bias_ext;
  logic signed [ACC_WIDTH-1:0]  rounded;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic signed [13:0]           sat;

  assign accept   = prod_vld & prod_rdy;
  assign prod_ext = {{(ACC_WIDTH-22){prod_din[21]}}, prod_din};
  assign bias_ext = {{(ACC_WIDTH-14){bias_din[13]}}, bias_din};

  // Round half up, then floor via arithmetic shift; the accumulator has headroom for the add.
  always_comb begin
    rounded = acc + ROUND_C;
    shifted = rounded >>> SHIFT;
    if (shifted > OUT_MAX) begin
      sat = 14'sd8191;
    end else if (shifted < OUT_MIN) begin
      sat = -14'sd8192;
    end else begin
      sat = shifted[13:0];
    end
`ifdef CNN_ACC_REQUANT_RELU_EN
    if (sat[13]) begin
      sat = 14'sd0;
    end
`else
`endif
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      out_dout <= '0;
      out_vld  <= 1'b0;
      busy     <= 1'b0;
      prod_rdy <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc   <= prod_ext + (bias_ext <<< SHIFT);
            count <= CW'(1);
            busy  <= 1'b1;
            if (NUM_TERMS == 1) begin
              state    <= ROUND;
              prod_rdy <= 1'b0;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (accept) begin
            acc   <= acc + prod_ext;
            count <= count + CW'(1);
            if (count == CW'(NUM_TERMS - 1)) begin
              state    <= ROUND;
              prod_rdy <= 1'b0;
            end
          end
        end
        ROUND: begin
          out_dout <= sat;
          out_vld  <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          if (out_rdy) begin
            out_vld  <= 1'b0;
            busy     <= 1'b0;
            prod_rdy <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          out_vld  <= 1'b0;
          busy     <= 1'b0;
          prod_rdy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_acc_requant_22s_14s.sv
// tb/tb_cnn_acc_requant_22s_14s.sv - directed vector bench for cnn_acc_requant_22s_14s (NUM_TERMS=4, SHIFT=8)
module tb_cnn_acc_requant_22s_14s;

  logic               ap_clk = 1'b0;
  logic               ap_rst;
  logic               prod_vld;
  logic               prod_rdy;
  logic signed [21:0] prod_din;
  logic signed [13:0] bias_din;
  logic               out_vld;
  logic               out_rdy;
  logic signed [13:0] out_dout;
  logic               busy;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int bias;
    int p[4];
    int gap;
    int exp;
  } vec_t;

  vec_t vecs[12];

  cnn_acc_requant_22s_14s #(.NUM_TERMS(4), .SHIFT(8), .ACC_WIDTH(32)) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .prod_vld (prod_vld),
    .prod_rdy (prod_rdy),
    .prod_din (prod_din),
    .bias_din (bias_din),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_dout (out_dout),
    .busy     (busy)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic int fx(input int e);
`ifdef CNN_ACC_REQUANT_RELU_EN
    return (e < 0) ? 0 : e;
`else
    return e;
`endif
  endfunction

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int b, input int p0, input int p1,
                         input int p2, input int p3, input int g, input int e);
    vecs[i].bias = b;
    vecs[i].p[0] = p0;
    vecs[i].p[1] = p1;
    vecs[i].p[2] = p2;
    vecs[i].p[3] = p3;
    vecs[i].gap  = g;
    vecs[i].exp  = e;
  endtask

  // mode 0: plain handshake, 1: out_rdy held low 5 cycles, 2: reset while in HOLD
  task automatic run_vec(input vec_t v, input int mode);
    int lat;
    for (int t = 0; t < 4; t++) begin
      check("prod_rdy_term", int'(prod_rdy), 1);
      prod_vld = 1'b1;
      prod_din = 22'(v.p[t]);
      bias_din = 14'(v.bias);
      tick();
      prod_vld = 1'b0;
      prod_din = 22'(12345);
      bias_din = 14'(77);
      if (t < 3) begin
        for (int g = 0; g < v.gap; g++) begin
          check("out_vld_low_acc", int'(out_vld), 0);
          tick();
        end
      end
    end
    lat = 0;
    while (!out_vld && lat < 8) begin
      tick();
      lat++;
    end
    check("latency", lat + 1, 2);
    check("out_dout", int'(out_dout), fx(v.exp));
    check("busy_hold", int'(busy), 1);
    check("prod_rdy_hold", int'(prod_rdy), 0);
    if (mode == 1) begin
      for (int k = 0; k < 5; k++) begin
        tick();
        check("hold_vld", int'(out_vld), 1);
        check("hold_dout", int'(out_dout), fx(v.exp));
        check("hold_prod_rdy", int'(prod_rdy), 0);
      end
    end
    if (mode == 2) begin
      ap_rst = 1'b1;
      tick();
      ap_rst = 1'b0;
      check("rst_hold_vld", int'(out_vld), 0);
      check("rst_hold_dout", int'(out_dout), 0);
      for (int k = 0; k < 4; k++) begin
        tick();
        check("rst_hold_no_vld", int'(out_vld), 0);
      end
    end else begin
      out_rdy = 1'b1;
      tick();
      out_rdy = 1'b0;
      check("idle_vld", int'(out_vld), 0);
      check("idle_busy", int'(busy), 0);
      check("idle_prod_rdy", int'(prod_rdy), 1);
      check("dout_retained", int'(out_dout), fx(v.exp));
    end
  endtask

  initial begin
    set_vec(0,     0,      256,      256,      256,      256, 0,     4);
    set_vec(1,     0,      128,        0,        0,        0, 0,     1);
    set_vec(2,     0,     -129,        0,        0,        0, 0,    -1);
    set_vec(3,     3,        0,        0,        0,        0, 0,     3);
    set_vec(4,     0,  2097151,  2097151,  2097151,  2097151, 0,  8191);
    set_vec(5,     0, -2097152, -2097152, -2097152, -2097152, 0, -8192);
    set_vec(6,     0,      256,      256,      256,      256, 3,     4);
    set_vec(7,     0,     -128,        0,        0,        0, 0,     0);
    set_vec(8,     0,      127,        0,        0,        0, 0,     0);
    set_vec(9,   100,      127,        0,        0,        0, 1,   100);
    set_vec(10,   -2,     1000,     -300,       50,        7, 2,     1);
    set_vec(11, -8192,       0,        0,        0,        0, 0, -8192);

    ap_rst   = 1'b1;
    prod_vld = 1'b0;
    prod_din = '0;
    bias_din = '0;
    out_rdy  = 1'b0;
    tick();
    tick();
    check("rst_vld", int'(out_vld), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_prod_rdy", int'(prod_rdy), 1);
    check("rst_dout", int'(out_dout), 0);
    ap_rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], (i == 0) ? 1 : 0);
    end

    // reset after two terms, with a product offered during the reset cycle
    for (int t = 0; t < 2; t++) begin
      prod_vld = 1'b1;
      prod_din = 22'(999);
      tick();
    end
    prod_din = 22'(5000);
    ap_rst   = 1'b1;
    tick();
    ap_rst   = 1'b0;
    prod_vld = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_prod_rdy", int'(prod_rdy), 1);
    for (int k = 0; k < 4; k++) begin
      check("midrst_no_vld", int'(out_vld), 0);
      tick();
    end
    run_vec(vecs[0], 0);

    run_vec(vecs[4], 2);
    run_vec(vecs[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
